inst_rom_loader: RTL and testbench

INST_ROM_LOADER -- requirements
Module: inst_rom_loader

---
 rtl/inst_rom_loader_pkg.sv | 19 +
 rtl/inst_rom_loader_mem.sv | 25 ++
 rtl/inst_rom_loader.sv | 112 +++++++++++
 tb/tb_inst_rom_loader.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/inst_rom_loader_pkg.sv
// Shared types for the instruction ROM loader: FSM encoding and sizing.
// CHK state exists only when ROM_LOADER_CHECKSUM_EN is defined.
package inst_rom_loader_pkg;

    localparam int DEFAULT_DEPTH_WORDS = 1024;
    localparam int HDR_BYTES           = 2;

    typedef enum logic [2:0] {
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
`ifdef ROM_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_RUN,
        S_ERR
    } state_t;

endpackage

// File: rtl/inst_rom_loader_mem.sv
// Single write-port, asynchronous-read instruction memory.
// Contents are deliberately not reset.
module inst_rom_mem
    import inst_rom_loader_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int IDX_W       = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_rom_loader.sv
// Byte-stream instruction ROM loader holding the CPU in reset until loaded.
// Define ROM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int IDX_W       = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid_i,
    input  logic [7:0]  load_byte_i,
    output logic        load_ready_o,
    input  logic        rom_ce_i,
    input  logic [31:0] rom_addr_i,
    output logic [31:0] rom_data_o,
    output logic        cpu_rst_o,
    output logic        load_done_o,
    output logic        overflow_o,
    output logic        err_o
);

`ifdef ROM_LOADER_CHECKSUM_EN
    localparam state_t DONE_ST = S_CHK;
    logic [7:0] csum;
`else
    localparam state_t DONE_ST = S_RUN;
`endif

    state_t      state;
    logic [15:0] n_words;
    logic [15:0] k;
    logic [1:0]  bcnt;
    logic [23:0] shreg;
    logic        fire;
    logic        k_ovf;
    logic        we;
    logic [31:0] rdata;
    logic        unused_addr;

    assign fire  = load_valid_i && load_ready_o;
    assign k_ovf = 32'(k) >= DEPTH_WORDS;
    assign we    = fire && (state == S_DATA) && (bcnt == 2'd3) && !k_ovf;

    assign load_ready_o = (state != S_RUN) && (state != S_ERR);
    assign cpu_rst_o    = (state != S_RUN);
    assign load_done_o  = (state == S_RUN);
`ifdef ROM_LOADER_CHECKSUM_EN
    assign err_o = (state == S_ERR);
`else
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_CNT_HI;
            n_words    <= '0;
            k          <= '0;
            bcnt       <= '0;
            shreg      <= '0;
            overflow_o <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else if (fire) begin
            case (state)
                S_CNT_HI: begin
                    n_words[15:8] <= load_byte_i;
                    state         <= S_CNT_LO;
                end
                S_CNT_LO: begin
                    n_words[7:0] <= load_byte_i;
                    if ({n_words[15:8], load_byte_i} != 16'd0) state <= S_DATA;
                    else state <= DONE_ST;
                end
                S_DATA: begin
                    bcnt  <= bcnt + 2'd1;
                    shreg <= {shreg[15:0], load_byte_i};
`ifdef ROM_LOADER_CHECKSUM_EN
                    csum  <= csum ^ load_byte_i;
`endif
                    if (bcnt == 2'd3) begin
                        k <= k + 16'd1;
                        if (k_ovf) overflow_o <= 1'b1;
                        if (k + 16'd1 == n_words) state <= DONE_ST;
                    end
                end
`ifdef ROM_LOADER_CHECKSUM_EN
                S_CHK: state <= (load_byte_i == csum) ? S_RUN : S_ERR;
`endif
                default: ;
            endcase
        end
    end

    inst_rom_mem #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_mem (
        .clk  (clk),
        .we   (we),
        .waddr(k[IDX_W-1:0]),
        .wdata({shreg, load_byte_i}),
        .raddr(rom_addr_i[IDX_W+1:2]),
        .rdata(rdata)
    );

    // Upper address bits wrap and byte offset is ignored.
    assign unused_addr = ^{rom_addr_i[31:IDX_W+2], rom_addr_i[1:0]};
    assign rom_data_o  = rom_ce_i ? rdata : 32'h0;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed self-checking bench for inst_rom_loader (1024-word and 4-word).
// Checksum cases run only when ROM_LOADER_CHECKSUM_EN is defined.
module tb_inst_rom_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lv = 1'b0, v4 = 1'b0;
    logic [7:0]  lb = 8'h0, b4 = 8'h0;
    logic        ce = 1'b0;
    logic [31:0] addr = 32'h0;
    logic        rdy, rdy4, crst, crst4, done, done4, ovf, ovf4, err, err4;
    logic [31:0] rdata, rdata4;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    inst_rom_loader dut (
        .clk(clk), .rst(rst),
        .load_valid_i(lv), .load_byte_i(lb), .load_ready_o(rdy),
        .rom_ce_i(ce), .rom_addr_i(addr), .rom_data_o(rdata),
        .cpu_rst_o(crst), .load_done_o(done),
        .overflow_o(ovf), .err_o(err)
    );

    inst_rom_loader #(.DEPTH_WORDS(4), .IDX_W(2)) dut4 (
        .clk(clk), .rst(rst),
        .load_valid_i(v4), .load_byte_i(b4), .load_ready_o(rdy4),
        .rom_ce_i(ce), .rom_addr_i(addr), .rom_data_o(rdata4),
        .cpu_rst_o(crst4), .load_done_o(done4),
        .overflow_o(ovf4), .err_o(err4)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic send(input logic [7:0] b, input bit to4);
        if (to4) begin v4 = 1'b1; b4 = b; end
        else begin lv = 1'b1; lb = b; end
        @(posedge clk); #1;
        lv = 1'b0;
        v4 = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit to4,
                             input bit gap);
        for (int i = 3; i >= 0; i--) begin
            send(w[i*8 +: 8], to4);
            if (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic rd(input string tag, input logic [31:0] a,
                      input logic [31:0] exp, input bit to4);
        ce = 1'b1;
        addr = a;
        #1;
        check(tag, to4 ? rdata4 : rdata, exp);
        ce = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", rdy, 1);
        check("rst_cpu_rst", crst, 1);
        check("rst_done", done, 0);
        check("rst_ovf", ovf, 0);
        check("rst_err", err, 0);
        rst = 1'b0;

        // Single word image
        send(8'h00, 0); send(8'h01, 0);
        send(8'h34, 0); send(8'h02, 0); send(8'h00, 0);
        check("w1_cpu_rst_before", crst, 1);
        send(8'h10, 0);
        check("w1_cpu_rst_after", crst, 0);
        check("w1_done", done, 1);
        check("w1_ready", rdy, 0);
        check("w1_err", err, 0);
        rd("w1_mem0", 32'h0, 32'h34020010, 0);
        rd("w1_offset", 32'h3, 32'h34020010, 0);
        rd("w1_wrap", 32'h1000, 32'h34020010, 0);
        addr = 32'h0;
        #1;
        check("w1_ce_off", rdata, 32'h0);
        send(8'h00, 0);
        check("run_ignores", done, 1);

        // Empty image
        do_reset();
        send(8'h00, 0);
        send(8'h00, 0);
        check("n0_done", done, 1);
        check("n0_cpu_rst", crst, 0);
        rd("n0_mem_kept", 32'h0, 32'h34020010, 0);

        // Gapped valid, 3 words
        do_reset();
        send(8'h00, 0); @(posedge clk); #1;
        send(8'h03, 0); @(posedge clk); #1;
        send_word(32'hDEADBEEF, 0, 1);
        rd("gap_during_load", 32'h0, 32'hDEADBEEF, 0);
        check("gap_ready_mid", rdy, 1);
        send_word(32'h01234567, 0, 1);
        send_word(32'hA5A55A5A, 0, 1);
        check("gap_ready_end", rdy, 0);
        check("gap_done", done, 1);
        rd("gap_mem0", 32'h0, 32'hDEADBEEF, 0);
        rd("gap_mem1", 32'h4, 32'h01234567, 0);
        rd("gap_mem2", 32'h8, 32'hA5A55A5A, 0);

        // Overflow on 4-word instance
        do_reset();
        send(8'h00, 1); send(8'h05, 1);
        send_word(32'h11111111, 1, 0);
        send_word(32'h22222222, 1, 0);
        send_word(32'h33333333, 1, 0);
        send_word(32'h44444444, 1, 0);
        check("ovf_before", ovf4, 0);
        send_word(32'h55555555, 1, 0);
        check("ovf_after", ovf4, 1);
        check("ovf_done", done4, 1);
        rd("ovf_mem0", 32'h0, 32'h11111111, 1);
        rd("ovf_mem3", 32'hC, 32'h44444444, 1);
        rd("ovf_wrap", 32'h10, 32'h11111111, 1);

        // Abort mid-load, then reload
        do_reset();
        send(8'h00, 0); send(8'h01, 0);
        send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0);
        do_reset();
        check("abort_ready", rdy, 1);
        check("abort_cpu_rst", crst, 1);
        check("abort_done", done, 0);
        send(8'h00, 0); send(8'h01, 0);
        send_word(32'hCAFEBABE, 0, 0);
        check("abort_reload_done", done, 1);
        rd("abort_mem0", 32'h0, 32'hCAFEBABE, 0);
        check("abort_ovf", ovf, 0);

`ifdef ROM_LOADER_CHECKSUM_EN
        do_reset();
        send(8'h00, 0); send(8'h01, 0);
        send_word(32'h11223344, 0, 0);
        check("chk_wait_cpu_rst", crst, 1);
        check("chk_wait_ready", rdy, 1);
        send(8'h44, 0);
        check("chk_ok_done", done, 1);
        check("chk_ok_err", err, 0);
        do_reset();
        send(8'h00, 0); send(8'h01, 0);
        send_word(32'h11223344, 0, 0);
        send(8'h45, 0);
        check("chk_bad_err", err, 1);
        check("chk_bad_cpu_rst", crst, 1);
        check("chk_bad_done", done, 0);
        check("chk_bad_ready", rdy, 0);
        rd("chk_bad_mem0", 32'h0, 32'h11223344, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
